hazard_control: RTL
===================

Name: hazard_control

Overview:
- Pipeline hazard and stall controller for the 5-stage core.
- Sits beside the EX-stage forwarding logic and covers the cases bypassing cannot resolve:
  - load-use dependencies;
  - multi-cycle EX operations;
  - data-memory wait states;
  - taken-branch squashes.
- Produces hold, bubble and flush controls for the PC and the IF/ID, ID/EX and EX/MEM pipeline registers, plus a stall-cycle performance counter.

Parameters:
- MC_LATENCY, 4, number of cycles a multi-cycle EX operation stalls the front end; legal range 2..15.
- CNT_W, 16, width of the stall_cycles performance counter.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- id_rs1  input  5  source register 1 of the instruction in ID.
- id_rs2  input  5  source register 2 of the instruction in ID.
- id_use_rs1  input  1  ID instruction reads rs1.
- id_use_rs2  input  1  ID instruction reads rs2.
- id_ex_rd  input  5  destination register of the instruction in EX.
- id_ex_reg_write  input  1  EX instruction writes id_ex_rd.
- id_ex_mem_read  input  1  EX instruction is a load.
- id_ex_multicycle  input  1  EX instruction is a multi-cycle op (mul/div).
- ex_branch_taken  input  1  EX resolved a taken branch or jump this cycle.
- mem_busy  input  1  data memory not ready; MEM stage cannot complete.
- pc_stall  output  1  hold PC.
- if_id_stall  output  1  hold IF/ID.
- id_ex_stall  output  1  hold ID/EX.
- ex_mem_stall  output  1  hold EX/MEM.
- id_ex_bubble  output  1  load NOP into ID/EX at next edge.
- if_id_flush  output  1  load NOP into IF/ID at next edge.
- busy  output  1  FSM not in IDLE.
- stall_cycles  output  CNT_W  saturating count of cycles with pc_stall=1.

Behaviour:
- Interface:
  - One clock, clk.
  - Reset rst is synchronous and active-high.
  - While rst=1 all outputs are 0. At the first edge with rst=1: state=IDLE, cnt=0, stall_cycles=0.
- Control outputs are combinational from the current inputs plus the registered state. No added latency.
- State register: IDLE, MC_BUSY. A 4-bit down-counter cnt is used in MC_BUSY.
- Priority, highest first: rst > mem_busy > MC_BUSY > branch flush > multi-cycle entry > load-use.
- mem_busy=1 (any state):
  - pc_stall, if_id_stall, id_ex_stall and ex_mem_stall are all 1.
  - bubble=0 and flush=0.
  - FSM and cnt are frozen; branch handling is deferred.
  - ex_branch_taken stays asserted because EX is held, so the flush takes effect in the first cycle with mem_busy=0.
- MC_BUSY, mem_busy=0:
  - pc_stall, if_id_stall, id_ex_stall and ex_mem_stall are 1.
  - Outputs id_ex_bubble=0 and if_id_flush=0.
  - If cnt==1, next state is IDLE; otherwise cnt decrements.
- IDLE, ex_branch_taken=1: if_id_flush=1 and id_ex_bubble=1, with no stalls. Load-use detection is suppressed, since the ID instruction is squashed.
- IDLE, id_ex_multicycle=1 (no branch):
  - All four stalls are 1.
  - cnt loads MC_LATENCY-1 and the next state is MC_BUSY.
  - Total consecutive stall cycles = MC_LATENCY.
- IDLE, load-use hazard:
  - Condition: id_ex_mem_read & id_ex_reg_write & id_ex_rd!=0 & ((id_use_rs1 & id_rs1==id_ex_rd) | (id_use_rs2 & id_rs2==id_ex_rd)).
  - Response: pc_stall=1, if_id_stall=1, id_ex_bubble=1, with id_ex_stall=0 and ex_mem_stall=0.
  - Exactly one stall cycle. Next cycle the load is in MEM, so the hazard clears and forwarding supplies the value.
- Register x0 never causes a hazard.
- busy = (state==MC_BUSY).
- stall_cycles:
  - Increments on each edge where pc_stall=1 and rst=0.
  - Saturates at all-ones with no wrap.
- rst asserted during MC_BUSY: IDLE at that edge, with cnt=0 and stall_cycles=0.
- mem_busy rising during MC_BUSY: cnt holds and resumes when mem_busy falls, so the total MC_BUSY length is extended by the mem_busy cycles.

Test Plan:
- Reset: hold rst 2 cycles with all inputs random → every output 0 and stall_cycles=0. Release → busy=0.
- Load-use: id_ex_mem_read=1, id_ex_reg_write=1, id_ex_rd=5, id_rs2=5, id_use_rs2=1 → one cycle of pc_stall=1, if_id_stall=1, id_ex_bubble=1; stall_cycles=1 afterwards. Repeat with id_ex_rd=0 → no stall.
- Multi-cycle: MC_LATENCY=4, pulse id_ex_multicycle for 1 cycle → stalls high exactly 4 consecutive cycles, busy high cycles 2–4, stall_cycles=4.
- Memory wait inside multi-cycle: mem_busy=1 for 3 cycles starting at MC_BUSY cycle 2 → stalls high 7 cycles total, cnt unchanged during the wait.
- Branch vs load-use: ex_branch_taken=1 together with a load-use match → if_id_flush=1, id_ex_bubble=1, pc_stall=0. With mem_busy=1 for 2 cycles and the branch held → flush only in the cycle after mem_busy falls.
- Saturation/reset: CNT_W=4, hold mem_busy 20 cycles → stall_cycles=15. Assert rst mid-MC_BUSY → state IDLE and stall_cycles=0 next cycle.

Source files
------------

// File: rtl/hazard_if.sv
// Hazard controller port bundle: pipeline status into the controller, stall/flush controls out.
interface hazard_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [4:0]       id_ex_rd;
  logic             id_ex_reg_write;
  logic             id_ex_mem_read;
  logic             id_ex_multicycle;
  logic             ex_branch_taken;
  logic             mem_busy;
  logic             pc_stall;
  logic             if_id_stall;
  logic             id_ex_stall;
  logic             ex_mem_stall;
  logic             id_ex_bubble;
  logic             if_id_flush;
  logic             busy;
  logic [CNT_W-1:0] stall_cycles;

  // Pipeline side: supplies hazard status, consumes controls.
  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_ex_rd, id_ex_reg_write,
           id_ex_mem_read, id_ex_multicycle, ex_branch_taken, mem_busy,
    input  pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, id_ex_bubble,
           if_id_flush, busy, stall_cycles
  );

  // Controller side.
  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_ex_rd, id_ex_reg_write,
           id_ex_mem_read, id_ex_multicycle, ex_branch_taken, mem_busy,
    output pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, id_ex_bubble,
           if_id_flush, busy, stall_cycles
  );
endinterface

// File: rtl/hazard_control.sv
// Hazard/stall controller for the 5-stage core: load-use, multi-cycle EX, memory wait
// and taken-branch squash, plus a saturating stall-cycle counter.
module hazard_control #(
  parameter int unsigned MC_LATENCY = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic     clk,
  input  logic     rst,
  hazard_if.slave  hz
);

  localparam logic [3:0] CNT_LOAD = 4'(MC_LATENCY - 1);

  typedef enum logic {
    IDLE,
    MC_BUSY
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q;

  logic load_use;
  logic pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, id_ex_bubble, if_id_flush;

  // x0 is hardwired zero, so a load targeting it can never create a dependency.
  always_comb begin
    load_use = hz.id_ex_mem_read && hz.id_ex_reg_write && (hz.id_ex_rd != 5'd0) &&
               ((hz.id_use_rs1 && (hz.id_rs1 == hz.id_ex_rd)) ||
                (hz.id_use_rs2 && (hz.id_rs2 == hz.id_ex_rd)));
  end

  // Next state and controls, highest-priority cause first.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_stall  = 1'b0;
    ex_mem_stall = 1'b0;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    if (rst) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
    end else if (hz.mem_busy) begin
      // Whole pipe frozen; a pending branch stays visible in EX and flushes afterwards.
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
    end else if (state_q == MC_BUSY) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
      if (cnt_q == 4'd1) begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end else if (hz.ex_branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (hz.id_ex_multicycle) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
      cnt_d        = CNT_LOAD;
      state_d      = MC_BUSY;
    end else if (load_use) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (pc_stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  assign hz.pc_stall     = pc_stall;
  assign hz.if_id_stall  = if_id_stall;
  assign hz.id_ex_stall  = id_ex_stall;
  assign hz.ex_mem_stall = ex_mem_stall;
  assign hz.id_ex_bubble = id_ex_bubble;
  assign hz.if_id_flush  = if_id_flush;
  assign hz.busy         = !rst && (state_q == MC_BUSY);
  assign hz.stall_cycles = rst ? '0 : stall_cnt_q;

endmodule
